// File: rtl/ddr_writer_pkg.sv
// Shared types and constants for the DDR frame burst writer.
package ddr_writer_pkg;

  localparam int unsigned AWLEN_W   = 4;
  localparam int unsigned MAX_BURST = 16;
  localparam int unsigned BUF_IDX_W = 3;
  localparam int unsigned LEN_W     = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    IDLE,
    AW,
    WDATA
  } wr_state_e;

endpackage

// File: rtl/burst_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy count.
// Ports: clk/rst, push+wr_data in, pop in, rd_data = head word,
//        count = occupancy, full/empty flags.
module burst_fifo #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned DEPTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic [$clog2(DEPTH+1)-1:0]     count,
  output logic                           full,
  output logic                           empty
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer / count update; overflowing push and underflowing pop are ignored
  always_comb begin
    do_push  = push && (cnt_q != CNT_W'(DEPTH));
    do_pop   = pop && (cnt_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = cnt_q;
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);

endmodule

// File: rtl/ddr_frame_burst_writer.sv
// Frame writer: buffers a pixel-word stream and writes it as AXI-style bursts
// into rotating DDR frame buffers.
// Ports: in_* = input stream (valid/ready, sof marks first word of a frame);
//        axi_aw* = burst address channel; axi_w* = write beats from FIFO head,
//        axi_wusero_last = DDR IP end-of-burst flag; wr_buf = buffer in use;
//        frame_done / frame_abort = 1-cycle pulses; err = sticky protocol error.
module ddr_frame_burst_writer
  import ddr_writer_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 28,
  parameter int unsigned       DATA_W        = 256,
  parameter int unsigned       BURST_LEN     = 16,
  parameter int unsigned       FRAME_WORDS   = 57600,
  parameter int unsigned       FRAME_BUFS    = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR     = '0,
  parameter logic [ADDR_W-1:0] FRAME_STRIDE  = ADDR_W'(32'h0100000),
  parameter int unsigned       ADDR_PER_BEAT = 8
) (
  input  logic                  ddr_clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_W-1:0]     in_data,
  input  logic                  in_sof,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_W-1:0]     axi_awaddr,
  output logic [AWLEN_W-1:0]    axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [DATA_W-1:0]     axi_wdata,
  output logic [DATA_W/8-1:0]   axi_wstrb,
  input  logic                  axi_wready,
  input  logic                  axi_wusero_last,
  output logic [BUF_IDX_W-1:0]  wr_buf,
  output logic                  frame_done,
  output logic                  frame_abort,
  output logic                  err
);

  localparam int unsigned BO_W  = $clog2(FRAME_WORDS + 1);
  localparam int unsigned DEPTH = 2 * BURST_LEN;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wr_state_e            state_q, state_d;
  logic [BUF_IDX_W-1:0] wr_buf_q, wr_buf_d;
  logic                 active_q, active_d;
  logic [BO_W-1:0]      word_cnt_q, word_cnt_d;
  logic [BO_W-1:0]      beat_off_q, beat_off_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [ADDR_W-1:0]    awaddr_q, awaddr_d;
  logic [AWLEN_W-1:0]   awlen_q, awlen_d;
  logic                 awvalid_q, awvalid_d;
  logic                 flush_pend_q, flush_pend_d;
  logic                 err_q, err_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_abort_q, frame_abort_d;
  logic                 rdy_en_q;

  logic             fifo_full, fifo_empty, push, pop;
  logic [CNT_W-1:0] fifo_cnt;
  logic             frame_busy, sof_block, accept;
  logic             req;
  logic [LEN_W-1:0] req_len;
  logic [31:0]      cnt32, rem32;

  burst_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (ddr_clk),
    .rst     (rst),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (axi_wdata),
    .count   (fifo_cnt),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A new sof is held off until every beat of the current active frame is written
  always_comb begin
    frame_busy = active_q && (beat_off_q != BO_W'(FRAME_WORDS));
    sof_block  = in_valid && in_sof && frame_busy;
    in_ready   = rdy_en_q && !fifo_full && !flush_pend_q && !sof_block;
    accept     = in_valid && in_ready;
    push       = accept && (in_sof ? en : (active_q && (word_cnt_q != BO_W'(FRAME_WORDS))));
  end

  // Burst request: full bursts mid-frame, exact tail at frame end, anything left while flushing
  always_comb begin
    cnt32   = 32'(fifo_cnt);
    rem32   = 32'(BO_W'(FRAME_WORDS) - beat_off_q);
    req     = 1'b0;
    req_len = '0;
    if (flush_pend_q) begin
      if (cnt32 != 0) begin
        req     = 1'b1;
        req_len = (cnt32 >= BURST_LEN) ? LEN_W'(BURST_LEN) : LEN_W'(cnt32);
      end
    end else if (active_q && (rem32 != 0)) begin
      if (rem32 >= BURST_LEN) begin
        if (cnt32 >= BURST_LEN) begin
          req     = 1'b1;
          req_len = LEN_W'(BURST_LEN);
        end
      end else if (cnt32 == rem32) begin
        req     = 1'b1;
        req_len = LEN_W'(rem32);
      end
    end
  end

  // Next-state, burst control and frame bookkeeping
  always_comb begin
    state_d       = state_q;
    wr_buf_d      = wr_buf_q;
    active_d      = active_q;
    word_cnt_d    = word_cnt_q;
    beat_off_d    = beat_off_q;
    len_d         = len_q;
    beat_cnt_d    = beat_cnt_q;
    awaddr_d      = awaddr_q;
    awlen_d       = awlen_q;
    awvalid_d     = awvalid_q;
    flush_pend_d  = flush_pend_q;
    err_d         = err_q;
    frame_done_d  = 1'b0;
    frame_abort_d = 1'b0;
    pop           = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) begin
          state_d    = AW;
          len_d      = req_len;
          beat_cnt_d = '0;
          awvalid_d  = 1'b1;
          awlen_d    = AWLEN_W'(req_len - LEN_W'(1));
          awaddr_d   = BASE_ADDR + ADDR_W'(wr_buf_q) * FRAME_STRIDE
                     + ADDR_W'(beat_off_q) * ADDR_W'(ADDR_PER_BEAT);
        end else if (flush_pend_q && fifo_empty) begin
          flush_pend_d  = 1'b0;
          active_d      = 1'b0;
          frame_abort_d = 1'b1;
        end
      end
      AW: begin
        if (axi_awready) begin
          awvalid_d = 1'b0;
          state_d   = WDATA;
        end
      end
      WDATA: begin
        // Beats beyond the granted length are not popped; empty FIFO is an error
        if (axi_wready && (beat_cnt_q != len_q)) begin
          if (fifo_empty) begin
            err_d = 1'b1;
          end else begin
            pop        = 1'b1;
            beat_cnt_d = beat_cnt_q + LEN_W'(1);
          end
        end
        if (axi_wusero_last) begin
          state_d    = IDLE;
          beat_off_d = beat_off_q + BO_W'(len_q);
          if (beat_cnt_d != len_q) err_d = 1'b1;
          if (beat_off_d == BO_W'(FRAME_WORDS)) frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame start takes priority over the burst-end offset update
    if (accept && in_sof) begin
      active_d = en;
      if (en) begin
        wr_buf_d   = (wr_buf_q == BUF_IDX_W'(FRAME_BUFS - 1)) ? '0 : wr_buf_q + BUF_IDX_W'(1);
        word_cnt_d = BO_W'(1);
        beat_off_d = '0;
      end
    end else if (push) begin
      word_cnt_d = word_cnt_q + BO_W'(1);
    end

    if (sof_block && !flush_pend_q && (word_cnt_q != BO_W'(FRAME_WORDS))) flush_pend_d = 1'b1;
  end

  always_ff @(posedge ddr_clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      wr_buf_q      <= BUF_IDX_W'(FRAME_BUFS - 1);
      active_q      <= 1'b0;
      word_cnt_q    <= '0;
      beat_off_q    <= '0;
      len_q         <= '0;
      beat_cnt_q    <= '0;
      awaddr_q      <= '0;
      awlen_q       <= '0;
      awvalid_q     <= 1'b0;
      flush_pend_q  <= 1'b0;
      err_q         <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      rdy_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_buf_q      <= wr_buf_d;
      active_q      <= active_d;
      word_cnt_q    <= word_cnt_d;
      beat_off_q    <= beat_off_d;
      len_q         <= len_d;
      beat_cnt_q    <= beat_cnt_d;
      awaddr_q      <= awaddr_d;
      awlen_q       <= awlen_d;
      awvalid_q     <= awvalid_d;
      flush_pend_q  <= flush_pend_d;
      err_q         <= err_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      rdy_en_q      <= 1'b1;
    end
  end

  assign axi_awaddr  = awaddr_q;
  assign axi_awlen   = awlen_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wstrb   = (state_q == WDATA) ? '1 : '0;
  assign wr_buf      = wr_buf_q;
  assign frame_done  = frame_done_q;
  assign frame_abort = frame_abort_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ddr_frame_burst_writer.sv
// Directed bench for ddr_frame_burst_writer (FRAME_WORDS=20, BURST_LEN=16, 3 buffers).
module tb_ddr_frame_burst_writer;

  logic        ddr_clk = 1'b0;
  logic        rst = 1'b1;
  logic        en, in_sof, in_valid, in_ready;
  logic [31:0] in_data;
  logic [27:0] axi_awaddr;
  logic [3:0]  axi_awlen;
  logic        axi_awvalid, axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wready, axi_wusero_last;
  logic [2:0]  wr_buf;
  logic        frame_done, frame_abort, err;

  int checks = 0, failures = 0, timeouts = 0;
  int stab_viol = 0, strb_viol = 0, done_cnt = 0, abort_cnt = 0;
  int aw_base = 0, beat_base = 0;
  bit stall_mode = 0, hold_w = 0, open = 0;
  int early_last = 0, beats_left = 0, beats_done = 0;
  logic        prev_aw_wait = 1'b0;
  logic [27:0] prev_addr;
  logic [3:0]  prev_len;

  logic [27:0] got_addr[$], exp_addr[$];
  logic [3:0]  got_len[$],  exp_len[$];
  logic [31:0] got_data[$], exp_data[$];

  ddr_frame_burst_writer #(
    .ADDR_W(28), .DATA_W(32), .BURST_LEN(16), .FRAME_WORDS(20), .FRAME_BUFS(3),
    .BASE_ADDR(28'h0), .FRAME_STRIDE(28'h0100000), .ADDR_PER_BEAT(8)
  ) dut (
    .ddr_clk(ddr_clk), .rst(rst), .en(en), .in_data(in_data), .in_sof(in_sof),
    .in_valid(in_valid), .in_ready(in_ready), .axi_awaddr(axi_awaddr),
    .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wready(axi_wready),
    .axi_wusero_last(axi_wusero_last), .wr_buf(wr_buf), .frame_done(frame_done),
    .frame_abort(frame_abort), .err(err)
  );

  always #5 ddr_clk = ~ddr_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Hand-computed buffer base addresses (stride 0x100000)
  function automatic logic [27:0] buf_base(input int b);
    case (b)
      0:       return 28'h0000000;
      1:       return 28'h0100000;
      default: return 28'h0200000;
    endcase
  endfunction

  // 20-word frame: 16-beat burst at offset 0, 4-beat tail at offset 16*8 = 0x80
  task automatic exp_full_frame(input int b);
    exp_addr.push_back(buf_base(b));          exp_len.push_back(4'd15);
    exp_addr.push_back(buf_base(b) + 28'h80); exp_len.push_back(4'd3);
  endtask

  // AXI slave + monitor: drive at negedge, sample what the next posedge will see
  initial begin
    axi_awready = 1'b0; axi_wready = 1'b0; axi_wusero_last = 1'b0;
    forever begin
      @(negedge ddr_clk);
      axi_awready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_wready  = hold_w ? 1'b0 : (stall_mode ? 1'($urandom_range(0, 1)) : 1'b1);
      axi_wusero_last = axi_wready && open &&
                        ((early_last != 0) ? (beats_done + 1 == early_last) : (beats_left == 1));
      #1;
      if (rst) begin
        open = 0;
        prev_aw_wait = 1'b0;
      end else begin
        if (prev_aw_wait && (!axi_awvalid || axi_awaddr != prev_addr || axi_awlen != prev_len))
          stab_viol++;
        if (axi_wstrb != 4'h0 && (!open || axi_wstrb != 4'hF)) strb_viol++;
        if (open && axi_wstrb == 4'h0) strb_viol++;
        if (frame_done)  done_cnt++;
        if (frame_abort) abort_cnt++;
        if (open && axi_wready && axi_wstrb != 4'h0) begin
          got_data.push_back(axi_wdata);
          beats_done++;
          beats_left--;
          if (axi_wusero_last) open = 0;
        end
        if (axi_awvalid && axi_awready) begin
          got_addr.push_back(axi_awaddr);
          got_len.push_back(axi_awlen);
          open = 1;
          beats_left = int'(axi_awlen) + 1;
          beats_done = 0;
        end
        prev_aw_wait = axi_awvalid && !axi_awready;
        prev_addr    = axi_awaddr;
        prev_len     = axi_awlen;
      end
    end
  end

  task automatic send_word(input logic [31:0] d, input logic s, input int gap);
    int t;
    in_data = d; in_sof = s; in_valid = 1'b1;
    #1;
    t = 0;
    while (!in_ready && t < 3000) begin
      @(negedge ddr_clk);
      #1;
      t++;
    end
    if (t >= 3000) timeouts++;
    @(negedge ddr_clk);
    in_valid = 1'b0; in_sof = 1'b0;
    repeat (gap) @(negedge ddr_clk);
  endtask

  task automatic send_frame(input logic [7:0] id, input int n, input bit gaps, input bit keep);
    for (int i = 0; i < n; i++) begin
      logic [31:0] w;
      w = {id, 24'(i)};
      send_word(w, i == 0, gaps ? int'($urandom_range(0, 2)) : 0);
      if (keep) exp_data.push_back(w);
    end
  endtask

  task automatic wait_quiet();
    int t = 0;
    while ((got_data.size() < exp_data.size() || open) && t < 3000) begin
      @(negedge ddr_clk);
      t++;
    end
    if (t >= 3000) timeouts++;
    repeat (4) @(negedge ddr_clk);
  endtask

  task automatic phase_check(input string tag);
    int mism = 0;
    check({tag, "_aw_count"}, got_addr.size(), exp_addr.size());
    for (int i = aw_base; i < exp_addr.size() && i < got_addr.size(); i++) begin
      check($sformatf("%s_awaddr%0d", tag, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_awlen%0d", tag, i), got_len[i], exp_len[i]);
    end
    check({tag, "_beat_count"}, got_data.size(), exp_data.size());
    for (int i = beat_base; i < exp_data.size() && i < got_data.size(); i++)
      if (got_data[i] !== exp_data[i]) mism++;
    check({tag, "_data_order"}, mism, 0);
    aw_base   = exp_addr.size();
    beat_base = exp_data.size();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    en = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0;
    repeat (3) @(negedge ddr_clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_awvalid", axi_awvalid, 0);
    check("rst_wstrb", axi_wstrb, 0);
    check("rst_wr_buf", wr_buf, 2);
    check("rst_done_abort", {frame_done, frame_abort}, 0);
    check("rst_err", err, 0);
    @(negedge ddr_clk);
    rst = 1'b0;
    @(negedge ddr_clk);
    #1;
    check("ready_after_rst", in_ready, 1);

    // Stray words before any sof are dropped; four frames rotate 0,1,2,0
    send_word(32'hDEAD0001, 1'b0, 0);
    send_word(32'hDEAD0002, 1'b0, 0);
    for (int f = 0; f < 4; f++) begin
      send_frame(8'(f), 20, 1'b0, 1'b1);
      exp_full_frame(f % 3);
    end
    send_word(32'hEEEE0000, 1'b0, 0);
    wait_quiet();
    phase_check("t1");
    check("t1_frame_done", done_cnt, 4);
    check("t1_wr_buf", wr_buf, 0);

    // Random AW/W stalls with input gaps: buffers 1 and 2
    stall_mode = 1;
    send_frame(8'h04, 20, 1'b1, 1'b1); exp_full_frame(1);
    send_frame(8'h05, 20, 1'b1, 1'b1); exp_full_frame(2);
    wait_quiet();
    stall_mode = 0;
    phase_check("t4");
    check("t4_frame_done", done_cnt, 6);

    // Early sof after 10 words: 10-beat flush burst, abort, next frame in buffer 1
    send_frame(8'h06, 10, 1'b0, 1'b1);
    exp_addr.push_back(28'h0000000); exp_len.push_back(4'd9);
    send_frame(8'h07, 20, 1'b0, 1'b1);
    exp_full_frame(1);
    wait_quiet();
    phase_check("t5");
    check("t5_frame_abort", abort_cnt, 1);
    check("t5_frame_done", done_cnt, 7);

    // Capture disabled at sof: words accepted, nothing written, buffer unchanged
    en = 1'b0;
    send_frame(8'h08, 20, 1'b0, 1'b0);
    repeat (30) @(negedge ddr_clk);
    #1;
    check("t6_en0_ready", in_ready, 1);
    phase_check("t6_en0");
    check("t6_en0_wr_buf", wr_buf, 1);
    en = 1'b1;
    @(negedge ddr_clk);

    // Early wusero_last after 14 of 16 beats: sticky err
    early_last = 14;
    b0 = got_data.size();
    send_frame(8'h09, 20, 1'b0, 1'b0);
    for (int t = 0; t < 300 && (got_data.size() < b0 + 14 || open); t++) @(negedge ddr_clk);
    repeat (5) @(negedge ddr_clk);
    #1;
    check("t6_err_set", err, 1);
    check("t6_awaddr", got_addr.size() > aw_base ? got_addr[aw_base] : 28'hFFFFFFF, 28'h0200000);
    check("t6_aw_count", got_addr.size(), aw_base + 1);
    repeat (20) @(negedge ddr_clk);
    #1;
    check("t6_err_sticky", err, 1);
    early_last = 0;

    // Reset clears err; then reset mid-WDATA abandons the burst
    @(negedge ddr_clk);
    rst = 1'b1;
    @(negedge ddr_clk);
    rst = 1'b0;
    got_addr.delete(); got_len.delete(); got_data.delete();
    exp_addr.delete(); exp_len.delete(); exp_data.delete();
    aw_base = 0; beat_base = 0;
    @(negedge ddr_clk);
    hold_w = 1;
    send_frame(8'h0A, 16, 1'b0, 1'b0);
    for (int t = 0; t < 200 && got_addr.size() < 1; t++) @(negedge ddr_clk);
    repeat (3) @(negedge ddr_clk);
    #1;
    check("t6_first_buf_addr", got_addr.size() > 0 ? got_addr[0] : 28'hFFFFFFF, 28'h0000000);
    check("t6_wstrb_in_wdata", axi_wstrb, 4'hF);
    rst = 1'b1;
    #1;
    check("t6_rst_awvalid", axi_awvalid, 0);
    check("t6_rst_wstrb", axi_wstrb, 0);
    check("t6_rst_err", err, 0);
    check("t6_rst_wr_buf", wr_buf, 2);
    check("t6_rst_in_ready", in_ready, 0);
    @(negedge ddr_clk);
    rst = 1'b0;
    hold_w = 0;
    repeat (6) @(negedge ddr_clk);
    #1;
    check("t6_post_rst_idle", axi_wstrb, 0);
    check("t6_post_rst_no_aw", got_addr.size(), 1);
    check("t6_post_rst_ready", in_ready, 1);

    check("aw_stable_while_stalled", stab_viol, 0);
    check("wstrb_only_in_beats", strb_viol, 0);
    check("wait_timeouts", timeouts, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
